dsp48a1_mac_sequencer: RTL and testbench

Controller that drives one DSP48A1 instance to compute a signed dot product: sum over k = 0..len-1 of a[k] * b[k].
- Operands are accepted through a valid/ready stream.
- Per-term OPMODE is generated with the correct pipeline alignment.
- Bubbles are inserted on input stalls, and the 48-bit P result is captured after the drain.
- Sits between a stream source and a DSP48A1 configured with A0REG=1, B0REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT" and the remaining A1/B1/C/D/carry registers unused.

---
 rtl/dsp48a1_mac_sequencer.sv | 144 ++++++++++++++
 tb/tb_dsp48a1_mac_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp48a1_mac_sequencer.sv
`default_nettype none
// ============================================================================
// dsp48a1_mac_sequencer : streams signed operand pairs into a DSP48A1 and
// captures the 48-bit dot product after the pipeline drains.  Rev 1.0
// ============================================================================
module dsp48a1_mac_sequencer #(
   parameter int CNT_W     = 8,
   parameter int DRAIN_CYC = 3
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [17:0]       a_in,
   input  logic [17:0]       b_in,
   output logic [17:0]       dsp_a,
   output logic [17:0]       dsp_b,
   output logic [7:0]        dsp_opmode,
   output logic              dsp_ce,
   output logic              dsp_rst,
   input  logic [47:0]       dsp_p,
   output logic              busy,
   output logic [47:0]       result,
   output logic              result_valid
);

   localparam int             DW         = $clog2(DRAIN_CYC + 1);
   localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYC);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;
   typedef enum logic [1:0] {K_PRE, K_FIRST, K_ACC, K_POST} kind_t;

   state_t            state_q, state_d;
   kind_t             kind_q, kind_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic              first_done_q, first_done_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [17:0]       a_q, a_d, b_q, b_d;
   logic [7:0]        opmode_q, opmode_d;
   logic [47:0]       result_q, result_d;
   logic              hs;

   assign hs = (state_q == S_FEED) && in_valid;

   always_comb begin
      case (kind_q)
         K_FIRST: opmode_d = 8'h01;
         K_ACC:   opmode_d = 8'h09;
         K_POST:  opmode_d = 8'h08;
         default: opmode_d = 8'h00;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      kind_d       = K_PRE;
      remaining_d  = remaining_q;
      first_done_d = first_done_q;
      drain_d      = drain_q;
      a_d          = 18'd0;
      b_d          = 18'd0;
      result_d     = result_q;
      case (state_q)
         S_IDLE: begin
            drain_d = '0;
            if (start) begin
               if (len != '0) begin
                  remaining_d  = len;
                  first_done_d = 1'b0;
                  state_d      = S_FEED;
               end else begin
                  result_d = 48'd0;
                  state_d  = S_DONE;
               end
            end
         end
         S_FEED: begin
            if (hs) begin
               a_d          = a_in;
               b_d          = b_in;
               kind_d       = first_done_q ? K_ACC : K_FIRST;
               first_done_d = 1'b1;
               remaining_d  = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  drain_d = '0;
                  state_d = S_DRAIN;
               end
            end else begin
               kind_d = first_done_q ? K_POST : K_PRE;
            end
         end
         S_DRAIN: begin
            kind_d = K_POST;
            // P becomes valid DRAIN_CYC cycles after the final issue, which is
            // itself one cycle after the handshake, so capture one count later.
            if (drain_q == DRAIN_LAST) begin
               result_d = dsp_p;
               state_d  = S_DONE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q      <= S_IDLE;
         kind_q       <= K_PRE;
         remaining_q  <= '0;
         first_done_q <= 1'b0;
         drain_q      <= '0;
         a_q          <= 18'd0;
         b_q          <= 18'd0;
         opmode_q     <= 8'h00;
         result_q     <= 48'd0;
      end else begin
         state_q      <= state_d;
         kind_q       <= kind_d;
         remaining_q  <= remaining_d;
         first_done_q <= first_done_d;
         drain_q      <= drain_d;
         a_q          <= a_d;
         b_q          <= b_d;
         opmode_q     <= opmode_d;
         result_q     <= result_d;
      end
   end

   assign in_ready     = (state_q == S_FEED);
   assign dsp_ce       = (state_q == S_FEED) || (state_q == S_DRAIN);
   assign dsp_rst      = RST || ((state_q == S_IDLE) && start);
   assign busy         = (state_q != S_IDLE);
   assign result_valid = (state_q == S_DONE);
   assign dsp_a        = a_q;
   assign dsp_b        = b_q;
   assign dsp_opmode   = opmode_q;
   assign result       = result_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp48a1_mac_sequencer.sv
`default_nettype none
// ============================================================================
// tb_dsp48a1_mac_sequencer : directed bench with a behavioural DSP48A1 model
// and a result scoreboard checked by a separate monitor.  Rev 1.0
// ============================================================================
module tb_dsp48a1_mac_sequencer;

   logic        clk = 1'b0;
   logic        RST, start, in_valid, in_ready;
   logic [7:0]  len;
   logic [17:0] a_in, b_in, dsp_a, dsp_b;
   logic [7:0]  dsp_opmode;
   logic        dsp_ce, dsp_rst, busy, result_valid;
   logic [47:0] dsp_p, result;

   always #5 clk = ~clk;

   dsp48a1_mac_sequencer #(.CNT_W(8), .DRAIN_CYC(3)) dut (
      .clk(clk), .RST(RST), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
      .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p),
      .busy(busy), .result(result), .result_valid(result_valid)
   );

   // DSP48A1 with A0REG/B0REG/MREG/PREG/OPMODEREG enabled
   logic signed [17:0] a0, b0;
   logic signed [47:0] m, p;
   logic [7:0]         opr;
   always @(posedge clk) begin
      if (dsp_rst) begin
         a0 <= '0; b0 <= '0; m <= '0; opr <= '0; p <= '0;
      end else if (dsp_ce) begin
         a0  <= dsp_a;
         b0  <= dsp_b;
         m   <= a0 * b0;
         opr <= dsp_opmode;
         p   <= ((opr[1:0] == 2'b01) ? m : 48'sd0) + ((opr[3:2] == 2'b10) ? p : 48'sd0);
      end
   end
   assign dsp_p = p;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [47:0] val;
      int          due;
   } exp_t;
   exp_t       sbq[$];
   exp_t       mon_e;
   logic [7:0] trace[$];
   bit         rec_en    = 1'b0;
   bit         saw_ready = 1'b0;
   logic       prev_rv   = 1'b0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rec_en && dsp_ce) trace.push_back(dsp_opmode);
      if (in_ready) saw_ready = 1'b1;
      if (!RST) begin
         if (prev_rv) check("busy_after_done", 48'(busy), 48'd0);
         if (result_valid) begin
            if (sbq.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_result_valid: got result %0h expected no pulse", result);
            end else begin
               mon_e = sbq.pop_front();
               check("result", result, mon_e.val);
               check("result_latency_cycle", 48'(cyc), 48'(mon_e.due));
               check("busy_at_done", 48'(busy), 48'd1);
            end
         end
      end
      prev_rv = result_valid && !RST;
   end

   task automatic do_start(input logic [7:0] n);
      start = 1'b1; len = n;
      @(negedge clk);
      start = 1'b0; len = 8'd0;
   endtask

   // Handshake happens at the next rising edge; result_valid appears 4 edges later.
   task automatic send(input logic [17:0] a, input logic [17:0] b, input bit last,
                       input logic [47:0] expv);
      bit done = 1'b0;
      in_valid = 1'b1; a_in = a; b_in = b;
      for (int i = 0; i < 40 && !done; i++) begin
         if (in_ready) begin
            if (last) sbq.push_back('{expv, cyc + 5});
            done = 1'b1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0; a_in = '0; b_in = '0;
      if (!done) begin
         tests++; fails++;
         $display("FAIL handshake_timeout: got no in_ready expected handshake");
      end
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (sbq.size() == 0 && !busy && !result_valid) ok = 1'b1;
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL %s_timeout: got busy/pending expected idle", name);
      end
      sbq.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},     48'(in_ready),     48'd0);
      check({tag, "_dsp_a"},        48'(dsp_a),        48'd0);
      check({tag, "_dsp_b"},        48'(dsp_b),        48'd0);
      check({tag, "_dsp_opmode"},   48'(dsp_opmode),   48'd0);
      check({tag, "_dsp_ce"},       48'(dsp_ce),       48'd0);
      check({tag, "_dsp_rst"},      48'(dsp_rst),      48'd1);
      check({tag, "_busy"},         48'(busy),         48'd0);
      check({tag, "_result"},       result,            48'd0);
      check({tag, "_result_valid"}, 48'(result_valid), 48'd0);
   endtask

   task automatic check_trace(input string tag, input logic [7:0] exp[$]);
      check({tag, "_len"}, 48'(trace.size()), 48'(exp.size()));
      for (int i = 0; i < exp.size() && i < trace.size(); i++)
         check($sformatf("%s_op%0d", tag, i), 48'(trace[i]), 48'(exp[i]));
      trace.delete();
   endtask

   logic [7:0] exp_t1[$] = '{8'h00, 8'h00, 8'h01, 8'h09, 8'h09, 8'h08, 8'h08};
   logic [7:0] exp_t2[$] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h09,
                             8'h08, 8'h08, 8'h08, 8'h09, 8'h08, 8'h08};

   initial begin
      RST = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      RST = 1'b0;
      repeat (2) @(negedge clk);

      // Basic run, no stalls
      rec_en = 1'b1;
      do_start(8'd3);
      send(18'd2, 18'd5, 1'b0, 48'd0);
      send(18'd3, 18'd6, 1'b0, 48'd0);
      send(18'd4, 18'd7, 1'b1, 48'd56);
      wait_idle("basic");
      rec_en = 1'b0;
      check_trace("basic", exp_t1);

      // Same data with stalls before the first pair and between pairs 2 and 3
      rec_en = 1'b1;
      do_start(8'd3);
      repeat (2) @(negedge clk);
      send(18'd2, 18'd5, 1'b0, 48'd0);
      send(18'd3, 18'd6, 1'b0, 48'd0);
      repeat (3) @(negedge clk);
      send(18'd4, 18'd7, 1'b1, 48'd56);
      wait_idle("stall");
      rec_en = 1'b0;
      check_trace("stall", exp_t2);

      // Signed operands, including the most negative A
      do_start(8'd2);
      send(-18'sd3, 18'sd5, 1'b0, 48'd0);
      send(18'h20000, 18'd1, 1'b1, 48'hFFFF_FFFD_FFF1);
      wait_idle("signed");

      // Reset in FEED after one of four pairs
      do_start(8'd4);
      send(18'd9, 18'd9, 1'b0, 48'd0);
      RST = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      RST = 1'b0;
      @(negedge clk);
      do_start(8'd1);
      send(18'd7, 18'd7, 1'b1, 48'd49);
      wait_idle("after_rst");

      // Zero length: immediate DONE, result forced to zero, no in_ready
      saw_ready = 1'b0;
      start = 1'b1; len = 8'd0;
      sbq.push_back('{48'd0, cyc + 1});
      @(negedge clk);
      start = 1'b0;
      wait_idle("zero_len");
      check("zero_len_no_ready", 48'(saw_ready), 48'd0);

      // Start while busy is ignored in FEED and DRAIN
      do_start(8'd3);
      send(18'd2, 18'd5, 1'b0, 48'd0);
      start = 1'b1; len = 8'd1;
      check("busy_start_feed_dsp_rst", 48'(dsp_rst), 48'd0);
      send(18'd3, 18'd6, 1'b0, 48'd0);
      start = 1'b0;
      send(18'd4, 18'd7, 1'b1, 48'd56);
      start = 1'b1; len = 8'd1;
      check("busy_start_drain_dsp_rst", 48'(dsp_rst), 48'd0);
      check("busy_in_drain", 48'(busy), 48'd1);
      @(negedge clk);
      start = 1'b0; len = 8'd0;
      wait_idle("busy_start");

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of run");
      $fatal(1);
   end

endmodule
`default_nettype wire
